move_list_seq: RTL
==================

MOVE_LIST_SEQ -- requirements
Module: move_list_seq

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 17: RAM address of the first move entry.
REQ-002 SHALL have parameter HDR_ADDR, default 16: RAM address of the move-count header.
REQ-003 SHALL have parameter MAX_MOVES, default 255: move-entry capacity.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: one-cycle request to generate a move list.
REQ-007 SHALL have port busy, output, 1: high in every state except IDLE and DONE.
REQ-008 SHALL have port done, output, 1: list complete; held high until the next accepted start.
REQ-009 SHALL have port move_count, output, 15: number of moves written.
REQ-010 SHALL have port overflow, output, 1: capacity was hit on the last run.
REQ-011 SHALL have port lmg_reset, output, 1: reset pulse to the move generator.
REQ-012 SHALL have port lmg_done, input, 1: the generator has finished filling its FIFO.
REQ-013 SHALL have port lmg_rden, output, 1: FIFO pop.
REQ-014 SHALL have port lmg_fifo_out, input, 152: 8 slots of 19 bits; slot k occupies [19k+18:19k], with bit 19k+18 = invalid flag and [19k+17:19k] = move.
REQ-015 SHALL have port lmg_fifo_empty, input, 1: the FIFO holds no words.
REQ-016 SHALL have port host_wr, input, 1: the Avalon host owns the RAM write port this cycle.
REQ-017 SHALL have port ram_wren, output, 1: RAM write enable.
REQ-018 SHALL have port ram_wraddr, output, 15: RAM write address.
REQ-019 SHALL have port ram_data, output, 32: RAM write data.

Function
REQ-020 SHALL implement FSM states IDLE, LRST, WAIT, POP, LATCH, SCAN, HDR, TERM, DONE.
REQ-021 SHALL, in IDLE or DONE on start=1, clear move_count, overflow and done, and go to LRST; start SHALL be ignored in all other states.
REQ-022 SHALL assert lmg_reset for exactly the one LRST cycle, then go to WAIT.
REQ-023 SHALL remain in WAIT until lmg_done=1, then go to POP; if lmg_fifo_empty=1 at that point, it SHALL go to HDR instead.
REQ-024 SHALL assert lmg_rden for exactly one cycle in POP; the FIFO presents data the cycle after the pop, which LATCH registers into a 152-bit word register.
REQ-025 SHALL, in SCAN, examine one slot per cycle in order k=0..7 using a 3-bit slot counter.
REQ-026 SHALL, for a valid slot, write {14'b0, move[17:0]} to BASE_ADDR+move_count and increment move_count in the same cycle; an invalid slot SHALL take one cycle with no write.
REQ-027 SHALL, after slot 7, go to HDR if all 8 invalid flags were set or lmg_fifo_empty=1; otherwise it SHALL go to POP.
REQ-028 SHALL, when move_count reaches MAX_MOVES, set overflow, discard the remaining slots and words, and go to HDR.
REQ-029 SHALL, in HDR, write {17'b0, move_count} to HDR_ADDR, then go to TERM.
REQ-030 SHALL, in TERM, write 32'd0 to BASE_ADDR+move_count, then go to DONE.
REQ-031 SHALL drive done=1 in DONE and stay there until start.
REQ-032 SHALL, whenever host_wr=1 in a state that would write (SCAN with a valid slot, HDR, TERM), suppress ram_wren and hold all state, counters and the slot index; the pending write SHALL complete in the first cycle host_wr=0.
REQ-033 SHALL hold ram_wren=0 in all other cycles; ram_wraddr and ram_data are don't-care while ram_wren=0.
REQ-034 SHALL drive lmg_rden=0 outside POP and lmg_reset=0 outside LRST.
REQ-035 SHALL, if lmg_done drops while in POP, LATCH or SCAN, ignore it and finish the current word.

Reset
REQ-036 SHALL, on reset=1 at a clock edge, enter IDLE with busy=0, done=0, overflow=0, move_count=0, lmg_reset=0, lmg_rden=0 and ram_wren=0, regardless of state, including mid-scan or during a host stall.
REQ-037 SHALL not issue any partial write after reset; a start in the first post-reset cycle SHALL be accepted.

Verification
REQ-038 SHALL be verified with one FIFO word whose slots 0, 2 and 5 are valid (moves 0x00111, 0x00222, 0x00333) followed by an all-invalid word -> addr 17=0x111, 18=0x222, 19=0x333, HDR 16=3, addr 20=0, done=1, move_count=3.
REQ-039 SHALL be verified with lmg_done=1 and the FIFO empty -> HDR 16=0, addr 17=0, done=1, no lmg_rden pulse.
REQ-040 SHALL be verified with MAX_MOVES=4 and two fully valid words -> exactly 4 move writes (17..20), overflow=1, HDR=4, addr 21=0.
REQ-041 SHALL be verified with host_wr held high for 3 cycles during a valid SCAN slot -> no ram_wren in those cycles; the write lands at the same address afterwards and the final list is identical to the unstalled run.
REQ-042 SHALL be verified with reset asserted at slot 4 of the first word, then start -> outputs at reset values for one cycle; the rerun produces a correct list from addr 17 with a fresh lmg_reset pulse.
REQ-043 SHALL be verified with start pulsed while busy=1 -> ignored; a single lmg_reset pulse per accepted start.

Source files
------------

// File: rtl/move_list_seq.sv
// Move-list sequencer: drains the move generator FIFO into RAM,
// then writes the move-count header and a zero terminator.
module move_list_seq #(
  parameter int BASE_ADDR = 17,
  parameter int HDR_ADDR  = 16,
  parameter int MAX_MOVES = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [14:0]  move_count,
  output logic         overflow,
  output logic         lmg_reset,
  input  logic         lmg_done,
  output logic         lmg_rden,
  input  logic [151:0] lmg_fifo_out,
  input  logic         lmg_fifo_empty,
  input  logic         host_wr,
  output logic         ram_wren,
  output logic [14:0]  ram_wraddr,
  output logic [31:0]  ram_data
);

  typedef enum logic [3:0] {
    S_IDLE, S_LRST, S_WAIT, S_POP, S_LATCH,
    S_SCAN, S_HDR, S_TERM, S_DONE
  } state_t;

  localparam logic [14:0] BASE = 15'(BASE_ADDR);
  localparam logic [14:0] HDR  = 15'(HDR_ADDR);
  localparam logic [14:0] MAXC = 15'(MAX_MOVES);

  state_t         state_q, state_d;
  logic [151:0]   word_q, word_d;
  logic [2:0]     slot_q, slot_d;
  logic [14:0]    cnt_q, cnt_d;
  logic           ovf_q, ovf_d;
  logic           anyv_q, anyv_d;

  logic [7:0]     slot_base;
  logic [18:0]    slot_bits;
  logic [14:0]    cnt_inc;
  logic           wr;
  logic [14:0]    waddr;
  logic [31:0]    wdata;
  logic           lrst;
  logic           rden;

  assign slot_base = 8'(slot_q) * 8'd19;
  assign slot_bits = word_q[slot_base +: 19];
  assign cnt_inc   = cnt_q + 15'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      slot_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      anyv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      slot_q  <= slot_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      anyv_q  <= anyv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    slot_d  = slot_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    anyv_d  = anyv_q;
    wr      = 1'b0;
    waddr   = BASE + cnt_q;
    wdata   = '0;
    lrst    = 1'b0;
    rden    = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = S_LRST;
        end
      end
      S_LRST: begin
        lrst    = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (lmg_done)
          state_d = lmg_fifo_empty ? S_HDR : S_POP;
      end
      S_POP: begin
        rden    = 1'b1;
        state_d = S_LATCH;
      end
      S_LATCH: begin
        word_d  = lmg_fifo_out;
        slot_d  = '0;
        anyv_d  = 1'b0;
        state_d = S_SCAN;
      end
      S_SCAN: begin
        wdata = {14'b0, slot_bits[17:0]};
        if (!slot_bits[18]) begin
          // A host write owns the RAM port: freeze on this slot
          if (!host_wr) begin
            wr     = 1'b1;
            cnt_d  = cnt_inc;
            anyv_d = 1'b1;
            if (cnt_inc == MAXC) begin
              ovf_d   = 1'b1;
              state_d = S_HDR;
            end else if (slot_q == 3'd7) begin
              state_d = lmg_fifo_empty ? S_HDR : S_POP;
            end else begin
              slot_d = slot_q + 3'd1;
            end
          end
        end else if (slot_q == 3'd7) begin
          state_d = (!anyv_q || lmg_fifo_empty) ? S_HDR : S_POP;
        end else begin
          slot_d = slot_q + 3'd1;
        end
      end
      S_HDR: begin
        waddr = HDR;
        wdata = {17'b0, cnt_q};
        if (!host_wr) begin
          wr      = 1'b1;
          state_d = S_TERM;
        end
      end
      S_TERM: begin
        if (!host_wr) begin
          wr      = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done       = (state_q == S_DONE);
  assign move_count = cnt_q;
  assign overflow   = ovf_q;
  assign lmg_reset  = lrst;
  assign lmg_rden   = rden;
  assign ram_wren   = wr & ~reset;
  assign ram_wraddr = waddr;
  assign ram_data   = wdata;

endmodule
